systolic_feed_ctrl: RTL and testbench
=====================================

# systolic_feed_ctrl

Sequencer for one tile of the systolic array built from pipelined 8-bit MAC cells (registered multiply, then registered 24-bit add chained down each column). On `start` it issues row-skewed read enables and addresses to the per-row activation/weight buffers, tracks the array's fixed pipeline latency, and flags each column-bottom 24-bit result with a valid strobe and vector index. It sits between the tile command interface and the buffer banks and array, and owns no datapath arithmetic.

## Interface
- `ROWS`, default 4: array rows, which is also the column chain depth.
- `ADDR_W`, default 8: buffer address width. Maximum vector count is 2^ADDR_W.
- `clk` input, 1 bit: rising-edge clock.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `start` input, 1 bit: launch request. Sampled only in IDLE.
- `k_len` input, ADDR_W+1 bits: number of input vectors. Sampled with `start`.
- `abort` input, 1 bit: synchronous flush to IDLE. Highest priority after reset.
- `busy` output, 1 bit: high in every state except IDLE.
- `done` output, 1 bit: one-cycle completion pulse.
- `rd_en` output, ROWS bits: per-row read enable. It serves both the activation bank and the weight bank of that row.
- `rd_addr` output, ROWS*ADDR_W bits: per-row read address. Row r occupies bits [r*ADDR_W +: ADDR_W].
- `out_valid` output, 1 bit: column-bottom results are valid this cycle, in all columns simultaneously.
- `out_idx` output, ADDR_W bits: vector index of the current valid result.

## Operation
- States:
  - IDLE: waiting for `start`.
  - RUN: issuing reads and collecting results.
  - DONE: one cycle; pulses `done`.
- IDLE to RUN: `start`=1 and `k_len`≠0. Latch `k_len`; clear cycle counter `cnt` to 0.
- IDLE to DONE: `start`=1 and `k_len`=0. No reads and no `out_valid`.
- RUN: `cnt` increments every cycle.
  - Read side: `rd_en[r]`=1 iff r ≤ `cnt` < r+`k_len`; then `rd_addr[r]` = `cnt`−r. Otherwise `rd_addr[r]`=0.
  - Result side: `out_valid`=1 iff ROWS+2 ≤ `cnt` < ROWS+2+`k_len`; then `out_idx` = `cnt`−(ROWS+2). Otherwise `out_idx`=0.
- RUN to DONE: in the cycle where `cnt` = `k_len`+ROWS+1, which is the last `out_valid` cycle.
- DONE to IDLE: unconditional. `start` in DONE is ignored.
- `start` while busy is ignored; the latched `k_len` is unaffected.
- `abort`=1 in any state:
  - Next cycle: IDLE with all outputs 0 and no `done`.
  - An `abort` and a `start` asserted in the same IDLE cycle resolve to `abort`, which keeps IDLE.
- `cnt` width is ADDR_W+2 bits. It must reach 2^ADDR_W+ROWS+1 without wrap for ROWS ≤ 2^ADDR_W.
- Row 0 `prev_mac_o` is tied to 0 outside this block. The block does not clear array pipeline registers.

## Timing
- Buffer read latency is one cycle: data for `rd_en` at cycle t reaches the array `activ`/`weight` inputs at t+1.
- MAC latency is 2 cycles. Each row adds 1 cycle of partial-sum skew.
- Vector j result is at the bottom of all columns at RUN cycle j+ROWS+2.
- Total RUN length is `k_len`+ROWS+2 cycles. `done` follows in the next cycle.
- `busy` rises the cycle after the accepted `start` and falls the cycle after `done`.
- Reset, including mid-RUN: state IDLE, `cnt`=0, and every output 0 (`busy`, `done`, `rd_en`, `rd_addr`, `out_valid`, `out_idx`). Outputs are registered or decoded from registered state only.

## Structure
- Shared package holds:
  - State encoding (IDLE/RUN/DONE).
  - Latency constants: RD_LAT=1, MAC_LAT=2, and OUT_OFS = RD_LAT+MAC_LAT−1 = 2, used as ROWS+OUT_OFS.
- One sub-module, `row_skew_gen`, instantiated ROWS times with a row-index parameter. It decodes `rd_en[r]`/`rd_addr[r]` from `cnt` and `k_len`. The FSM, counter and result tagging stay in the top module.

## Test plan
- Reset mid-RUN:
  - Setup: ROWS=4, `k_len`=5; drop `rst_n` at `cnt`=3.
  - Required: all outputs 0 immediately.
  - After release: IDLE, and a new `start` runs normally.
- Nominal run:
  - Setup: ROWS=4, `k_len`=3.
  - Reads: `rd_en[0]` at cycles 0–2 with addr 0,1,2; `rd_en[3]` at cycles 3–5 with addr 0,1,2.
  - Results: `out_valid` at cycles 6–8 with `out_idx` 0,1,2.
  - Completion: `done` at cycle 9. Verify against a behavioral array model carrying 8-bit operands and 24-bit sums.
- Zero-length launch: `k_len`=0 → no `rd_en`, no `out_valid`, `done` the cycle after `start`.
- Maximum length:
  - Setup: ADDR_W=4, `k_len`=16.
  - Required: `rd_addr[r]` reaches 15 with no wrap; 16 `out_valid` pulses with `out_idx` 0..15; single `done`.
- Start while busy: `start` with `k_len`=7 during a `k_len`=4 run → ignored. Exactly 4 results, then `done`.
- Abort: `abort` at `cnt`=2 → IDLE next cycle, no `done`, no further `rd_en`. A `start`+`abort` in the same cycle leaves the block idle.

Source files
------------

// File: rtl/systolic_feed_ctrl_pkg.sv
// Shared definitions for the systolic tile feed sequencer: FSM encoding and
// the pipeline latency constants that place results relative to reads.
package systolic_feed_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Buffer read latency (enable at t, data at array inputs at t+1).
  localparam int RD_LAT  = 1;
  // Registered multiply followed by registered add in each MAC cell.
  localparam int MAC_LAT = 2;
  // Extra cycles beyond the row chain before a vector reaches the column bottom.
  localparam int OUT_OFS = RD_LAT + MAC_LAT - 1;

endpackage

// File: rtl/systolic_feed_ctrl_row_skew_gen.sv
// Per-row read enable/address decode. Row ROW_IDX reads vector j at cnt = j + ROW_IDX,
// which produces the diagonal skew the column partial-sum chain expects.
module row_skew_gen
  import systolic_feed_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int ROW_IDX = 0
) (
  input  logic              i_run,
  input  logic [ADDR_W+1:0] i_cnt,
  input  logic [ADDR_W:0]   i_k_len,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr
);
  // One extra bit so ROW_IDX + k_len never overflows the comparison.
  localparam int CMP_W = ADDR_W + 3;
  localparam logic [CMP_W-1:0]  ROW_LO = CMP_W'(ROW_IDX);
  localparam logic [ADDR_W-1:0] ROW_A  = ADDR_W'(ROW_IDX);

  logic [CMP_W-1:0] w_cnt;
  logic [CMP_W-1:0] w_hi;

  assign w_cnt = CMP_W'(i_cnt);
  assign w_hi  = ROW_LO + CMP_W'(i_k_len);

  // Enabled for the k_len cycles starting at this row's skew offset.
  assign o_rd_en = i_run && (w_cnt >= ROW_LO) && (w_cnt < w_hi);

  // Address is cnt - row; only the low bits matter since it is below 2^ADDR_W when enabled.
  assign o_rd_addr = o_rd_en ? (i_cnt[ADDR_W-1:0] - ROW_A) : '0;

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Tile feed sequencer: launches a k_len-vector pass through the systolic array,
// issues skewed buffer reads per row and tags column-bottom results.
module systolic_feed_ctrl
  import systolic_feed_ctrl_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int ADDR_W = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [ADDR_W:0]        i_k_len,
  input  logic                   i_abort,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [ROWS-1:0]        o_rd_en,
  output logic [ROWS*ADDR_W-1:0] o_rd_addr,
  output logic                   o_out_valid,
  output logic [ADDR_W-1:0]      o_out_idx
);
  localparam int CNT_W = ADDR_W + 2;
  localparam int CMP_W = ADDR_W + 3;
  // First RUN cycle carrying a valid column-bottom result.
  localparam logic [CMP_W-1:0]  RES_FIRST   = CMP_W'(ROWS + OUT_OFS);
  localparam logic [ADDR_W-1:0] RES_FIRST_A = ADDR_W'(ROWS + OUT_OFS);
  // Final RUN cycle is cnt = k_len + ROWS + OUT_OFS - 1 (last valid result).
  localparam logic [CMP_W-1:0]  LAST_OFS    = CMP_W'(ROWS + OUT_OFS - 1);

  state_t            r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic [ADDR_W:0]   r_k_len, w_k_len_next;

  logic              w_run;
  logic [CMP_W-1:0]  w_cnt_x;
  logic [CMP_W-1:0]  w_k_x;
  logic              w_last;

  assign w_run   = (r_state == ST_RUN);
  assign w_cnt_x = CMP_W'(r_cnt);
  assign w_k_x   = CMP_W'(r_k_len);
  assign w_last  = (w_cnt_x == (w_k_x + LAST_OFS));

  // State, cycle counter and latched vector count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_k_len <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_k_len <= w_k_len_next;
    end
  end

  // Next-state: abort overrides everything; zero-length launch goes straight to DONE.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_k_len_next = r_k_len;
    if (i_abort) begin
      w_state_next = ST_IDLE;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            w_k_len_next = i_k_len;
            w_cnt_next   = '0;
            w_state_next = (i_k_len == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          w_cnt_next = r_cnt + 1'b1;
          if (w_last) begin
            w_state_next = ST_DONE;
          end
        end
        ST_DONE: begin
          w_cnt_next   = '0;
          w_state_next = ST_IDLE;
        end
        default: begin
          w_cnt_next   = '0;
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Per-row skewed read decode.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    row_skew_gen #(
      .ADDR_W  (ADDR_W),
      .ROW_IDX (gi)
    ) u_skew (
      .i_run     (w_run),
      .i_cnt     (r_cnt),
      .i_k_len   (r_k_len),
      .o_rd_en   (o_rd_en[gi]),
      .o_rd_addr (o_rd_addr[gi*ADDR_W +: ADDR_W])
    );
  end

  assign o_busy      = (r_state != ST_IDLE);
  assign o_done      = (r_state == ST_DONE);
  assign o_out_valid = w_run && (w_cnt_x >= RES_FIRST) && (w_cnt_x < (RES_FIRST + w_k_x));
  assign o_out_idx   = o_out_valid ? (r_cnt[ADDR_W-1:0] - RES_FIRST_A) : '0;

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Bench for systolic_feed_ctrl: cycle-offset reference of the control outputs plus
// a behavioural MAC array fed from the DUT's reads to check result alignment.
module tb_systolic_feed_ctrl;
  localparam int ROWS   = 4;
  localparam int ADDR_W = 4;
  localparam int COLS   = 2;
  localparam int NVEC   = 1 << ADDR_W;

  logic                   clk   = 1'b0;
  logic                   rst_n = 1'b1;
  logic                   start = 1'b0;
  logic                   abort = 1'b0;
  logic [ADDR_W:0]        k_len = '0;
  logic                   busy, done, out_valid;
  logic [ROWS-1:0]        rd_en;
  logic [ROWS*ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0]      out_idx;

  systolic_feed_ctrl #(.ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_k_len     (k_len),
    .i_abort     (abort),
    .o_busy      (busy),
    .o_done      (done),
    .o_rd_en     (rd_en),
    .o_rd_addr   (rd_addr),
    .o_out_valid (out_valid),
    .o_out_idx   (out_idx)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Buffer contents: activation per row/vector, weight per row/column/vector.
  logic [7:0] act [ROWS][NVEC];
  logic [7:0] wt  [ROWS][COLS][NVEC];

  function automatic logic [23:0] ref_res(input int c, input int j);
    logic [23:0] s = '0;
    for (int r = 0; r < ROWS; r++) s += 24'(act[r][j]) * 24'(wt[r][c][j]);
    return s;
  endfunction

  // Reference: mdl_t = cycles since the accepted start (-1 when idle).
  int mdl_t = -1;
  int mdl_k = 0;

  function automatic int run_len(input int k);
    return (k == 0) ? 0 : k + ROWS + 2;
  endfunction

  task automatic check_cycle();
    logic [ROWS-1:0]        e_en   = '0;
    logic [ROWS*ADDR_W-1:0] e_addr = '0;
    logic                   e_ov   = 1'b0;
    logic [ADDR_W-1:0]      e_idx  = '0;
    bit act_now = (mdl_t >= 0);
    for (int r = 0; r < ROWS; r++) begin
      if (act_now && mdl_t >= r && mdl_t < r + mdl_k) begin
        e_en[r] = 1'b1;
        e_addr[r*ADDR_W +: ADDR_W] = ADDR_W'(mdl_t - r);
      end
    end
    if (act_now && mdl_t >= ROWS + 2 && mdl_t < ROWS + 2 + mdl_k) begin
      e_ov  = 1'b1;
      e_idx = ADDR_W'(mdl_t - ROWS - 2);
    end
    chk("busy",      64'(busy),      64'(act_now));
    chk("done",      64'(done),      64'(act_now && mdl_t == run_len(mdl_k)));
    chk("rd_en",     64'(rd_en),     64'(e_en));
    chk("rd_addr",   64'(rd_addr),   64'(e_addr));
    chk("out_valid", 64'(out_valid), 64'(e_ov));
    chk("out_idx",   64'(out_idx),   64'(e_idx));
  endtask

  // One clock: advance the reference on the edge, then compare just after it.
  task automatic tick();
    @(posedge clk);
    if (!rst_n || abort) mdl_t = -1;
    else if (mdl_t < 0) begin
      if (start) begin
        mdl_k = int'(k_len);
        mdl_t = 0;
      end
    end else if (mdl_t == run_len(mdl_k)) mdl_t = -1;
    else mdl_t++;
    #1;
    check_cycle();
  endtask

  // Behavioural array: buffer -> input reg -> product reg -> column sum chain.
  logic [7:0]      in_a [ROWS];
  logic [7:0]      in_w [ROWS][COLS];
  logic [15:0]     prod [ROWS][COLS];
  logic [23:0]     psum [ROWS][COLS];
  logic [ROWS-1:0] prev_en = '0;
  logic [ADDR_W-1:0] prev_addr [ROWS];
  int ov_cnt = 0, done_cnt = 0, max_addr = 0;

  always @(negedge clk) begin
    for (int r = ROWS - 1; r >= 0; r--)
      for (int c = 0; c < COLS; c++)
        psum[r][c] = ((r == 0) ? 24'd0 : psum[r-1][c]) + 24'(prod[r][c]);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        prod[r][c] = 16'(in_a[r]) * 16'(in_w[r][c]);
    for (int r = 0; r < ROWS; r++) begin
      if (prev_en[r]) begin
        in_a[r] = act[r][prev_addr[r]];
        for (int c = 0; c < COLS; c++) in_w[r][c] = wt[r][c][prev_addr[r]];
      end else begin
        in_a[r] = '0;
        for (int c = 0; c < COLS; c++) in_w[r][c] = '0;
      end
    end
    prev_en = rd_en;
    for (int r = 0; r < ROWS; r++) prev_addr[r] = rd_addr[r*ADDR_W +: ADDR_W];
    if (out_valid === 1'b1) begin
      ov_cnt++;
      for (int c = 0; c < COLS; c++)
        chk("array_sum", 64'(psum[ROWS-1][c]), 64'(ref_res(c, int'(out_idx))));
    end
    if (done === 1'b1) done_cnt++;
    if (rd_en[ROWS-1] === 1'b1 && int'(rd_addr[(ROWS-1)*ADDR_W +: ADDR_W]) > max_addr)
      max_addr = int'(rd_addr[(ROWS-1)*ADDR_W +: ADDR_W]);
  end

  task automatic clr_counts();
    ov_cnt = 0; done_cnt = 0; max_addr = 0;
  endtask

  task automatic launch(input int k);
    start = 1'b1;
    k_len = (ADDR_W+1)'(k);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (mdl_t >= 0 && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    for (int r = 0; r < ROWS; r++)
      for (int j = 0; j < NVEC; j++) begin
        act[r][j] = 8'($urandom);
        for (int c = 0; c < COLS; c++) wt[r][c][j] = 8'($urandom);
      end
    // Fixed extremes in vector 0 exercise the widest sums.
    for (int r = 0; r < ROWS; r++) begin
      act[r][0] = 8'hFF;
      for (int c = 0; c < COLS; c++) wt[r][c][0] = 8'hFF;
    end

    // Reset state.
    #2 rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Nominal k_len = 3.
    clr_counts();
    launch(3);
    wait_idle();
    chk("nom_results", 64'(ov_cnt), 64'd3);
    chk("nom_done", 64'(done_cnt), 64'd1);
    $display("txn nominal k=3 results=%0d done=%0d", ov_cnt, done_cnt);

    // Zero-length launch.
    clr_counts();
    launch(0);
    wait_idle();
    tick();
    chk("zero_results", 64'(ov_cnt), 64'd0);
    chk("zero_done", 64'(done_cnt), 64'd1);
    $display("txn zero k=0 results=%0d done=%0d", ov_cnt, done_cnt);

    // Maximum length.
    clr_counts();
    launch(NVEC);
    wait_idle();
    chk("max_results", 64'(ov_cnt), 64'(NVEC));
    chk("max_addr", 64'(max_addr), 64'(NVEC - 1));
    chk("max_done", 64'(done_cnt), 64'd1);
    $display("txn max k=%0d results=%0d done=%0d", NVEC, ov_cnt, done_cnt);

    // Start while busy is ignored.
    clr_counts();
    launch(4);
    tick();
    start = 1'b1; k_len = 5'd7;
    tick();
    start = 1'b0;
    wait_idle();
    chk("busy_start_results", 64'(ov_cnt), 64'd4);
    chk("busy_start_done", 64'(done_cnt), 64'd1);
    $display("txn start_while_busy k=4 results=%0d done=%0d", ov_cnt, done_cnt);

    // Abort at cnt = 2.
    clr_counts();
    launch(5);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (12) tick();
    chk("abort_done", 64'(done_cnt), 64'd0);
    chk("abort_results", 64'(ov_cnt), 64'd0);
    $display("txn abort k=5 results=%0d done=%0d", ov_cnt, done_cnt);

    // Start and abort together in IDLE stays idle.
    start = 1'b1; abort = 1'b1; k_len = 5'd3;
    tick();
    start = 1'b0; abort = 1'b0;
    repeat (3) tick();
    $display("txn start_abort_same_cycle busy=%0b", busy);

    // Reset mid-RUN at cnt = 3, then a normal run.
    launch(5);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    mdl_t = -1;
    check_cycle();
    tick();
    rst_n = 1'b1;
    tick();
    clr_counts();
    launch(6);
    wait_idle();
    chk("post_reset_results", 64'(ov_cnt), 64'd6);
    chk("post_reset_done", 64'(done_cnt), 64'd1);
    $display("txn reset_mid_run then k=6 results=%0d done=%0d", ov_cnt, done_cnt);

    // Randomized runs with stray start/abort pulses.
    for (int n = 0; n < 40; n++) begin
      int k = $urandom_range(0, NVEC);
      repeat ($urandom_range(0, 3)) tick();
      clr_counts();
      launch(k);
      while (mdl_t >= 0) begin
        start = ($urandom_range(0, 5) == 0);
        k_len = (ADDR_W+1)'($urandom_range(0, NVEC));
        abort = ($urandom_range(0, 79) == 0);
        tick();
      end
      start = 1'b0;
      abort = 1'b0;
      $display("txn rand %0d k=%0d results=%0d done=%0d", n, k, ov_cnt, done_cnt);
    end
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
